// File: rtl/uart_pkg.sv
// Shared UART definitions: feeder FSM states, launch pulse length and the
// frame-period helper used by both the transmit feeder and the receive side.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    WAIT  = 2'd2
  } feeder_state_t;

  // tx_en high time in sys_clk cycles
  localparam int PULSE_LEN = 2;

  // width of the launch/frame counter
  localparam int CNT_W = 24;

  // worst-case frame period: 16 bit-times of FREQ/BPS cycles each
  function automatic int frame_cycles(input int freq, input int bps);
    return 16 * (freq / bps);
  endfunction

endpackage

// File: rtl/uart_tx_feeder_if.sv
// Valid/ready byte write port into the transmit feeder.
interface uart_tx_feeder_if;

  logic [7:0] wr_data;
  logic       wr_valid;
  logic       wr_ready;

  modport master (
    output wr_data,
    output wr_valid,
    input  wr_ready
  );

  modport slave (
    input  wr_data,
    input  wr_valid,
    output wr_ready
  );

endinterface

// File: rtl/uart_tx_feeder_sync_fifo.sv
// Single-clock FIFO with occupancy counter. Full/empty come from the
// registered level, so they carry no combinational path from push/pop.
// The head entry is visible combinationally for the consumer to capture.
module sync_fifo #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [WIDTH-1:0]  push_data,
  input  logic              pop,
  output logic [WIDTH-1:0]  head,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level
);

  localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0]  mem_r [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_r;
  logic [ADDR_W-1:0] rd_ptr_r;
  logic [ADDR_W:0]   level_r;
  logic              push_ok_s;
  logic              pop_ok_s;

  // an overflowing push or underflowing pop is ignored rather than corrupting state
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;

  assign full  = (level_r == FULL_LVL);
  assign empty = (level_r == {(ADDR_W + 1){1'b0}});
  assign level = level_r;
  assign head  = mem_r[rd_ptr_r];

  // storage write; contents need no reset because level gates every read
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // pointers wrap modulo DEPTH; level tracks occupancy, unchanged on push+pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {ADDR_W{1'b0}};
      rd_ptr_r <= {ADDR_W{1'b0}};
      level_r  <= {(ADDR_W + 1){1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + {{(ADDR_W - 1){1'b0}}, 1'b1};
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + {{(ADDR_W - 1){1'b0}}, 1'b1};
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   level_r <= level_r + {{ADDR_W{1'b0}}, 1'b1};
        2'b01:   level_r <= level_r - {{ADDR_W{1'b0}}, 1'b1};
        default: level_r <= level_r;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Byte-buffering, rate-pacing front end for the UART transmitter. Bytes are
// queued in a FIFO and launched one at a time with a PULSE_LEN-cycle tx_en
// strobe; launches are spaced FRAME_CYCLES+1 cycles apart so the transmitter
// always completes a frame before the next byte arrives.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int BPS    = 9600,
  parameter int FREQ   = 50000000,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  uart_tx_feeder_if.slave   wr,
  output logic [7:0]        uart_din,
  output logic              tx_en,
  output logic              busy,
  output logic [ADDR_W:0]   level
);

  localparam int FRAME_CYCLES = frame_cycles(FREQ, BPS);
  localparam logic [CNT_W-1:0] PULSE_END = CNT_W'(PULSE_LEN);
  localparam logic [CNT_W-1:0] FRAME_END = CNT_W'(FRAME_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  if (FRAME_CYCLES >= 32'h0100_0000) begin : g_frame_too_long
    $error("uart_tx_feeder: frame period does not fit the 24-bit wait counter");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_feeder: DEPTH must be a power of two and at least 2");
  end

  feeder_state_t    state_r, state_n;
  logic [CNT_W-1:0] cnt_r, cnt_n;
  logic             tx_en_r, tx_en_n;
  logic [7:0]       din_r, din_n;
  logic             pop_s;
  logic             push_s;
  logic             full_s;
  logic             empty_s;
  logic [7:0]       head_s;

  assign push_s      = wr.wr_valid & ~full_s;
  assign wr.wr_ready = ~full_s;
  assign uart_din    = din_r;
  assign tx_en       = tx_en_r;
  assign busy        = (state_r != IDLE) | ~empty_s;

  sync_fifo #(
    .WIDTH  (8),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk       (sys_clk),
    .rst_n     (sys_rst_n),
    .push      (push_s),
    .push_data (wr.wr_data),
    .pop       (pop_s),
    .head      (head_s),
    .full      (full_s),
    .empty     (empty_s),
    .level     (level)
  );

  // FSM state, pacing counter and the registered transmitter outputs
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      tx_en_r <= 1'b0;
      din_r   <= 8'h00;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
      tx_en_r <= tx_en_n;
      din_r   <= din_n;
    end
  end

  // launch from IDLE, hold the strobe for PULSE_LEN cycles, then pace out the frame
  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    tx_en_n = tx_en_r;
    din_n   = din_r;
    pop_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (!empty_s) begin
          pop_s   = 1'b1;
          din_n   = head_s;
          tx_en_n = 1'b1;
          cnt_n   = CNT_ONE;
          state_n = PULSE;
        end else begin
          tx_en_n = 1'b0;
        end
      end
      PULSE: begin
        cnt_n = cnt_r + CNT_ONE;
        if (cnt_r == PULSE_END) begin
          tx_en_n = 1'b0;
          state_n = WAIT;
        end else begin
          tx_en_n = 1'b1;
        end
      end
      WAIT: begin
        tx_en_n = 1'b0;
        // PULSE and WAIT together occupy exactly FRAME_CYCLES cycles
        if (cnt_r == FRAME_END) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = {CNT_W{1'b0}};
        tx_en_n = 1'b0;
      end
    endcase
  end

endmodule
